// File: rtl/snn_step_sequencer.sv
// Timestep sequencer for the CartPole spiking network.
// Clears LIF state, pulses one enable per step, counts spikes, picks argmax.
module snn_step_sequencer #(
    parameter int NUM_STEPS   = 30,
    parameter int NUM_OUTPUTS = 2,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT     = 255
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   start,
    input  logic                                   step_done,
    input  logic [NUM_OUTPUTS-1:0]                 out_spikes,
    output logic                                   neuron_clear,
    output logic                                   step_enable,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   error,
    output logic [$clog2(NUM_STEPS+1)-1:0]         step_index,
    output logic [NUM_OUTPUTS*CNT_W-1:0]           spike_counts,
    output logic [(NUM_OUTPUTS > 2 ?
                   $clog2(NUM_OUTPUTS) : 1)-1:0]   action
);

    localparam int SW = $clog2(NUM_STEPS + 1);
    localparam int AW = (NUM_OUTPUTS > 2) ? $clog2(NUM_OUTPUTS) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [SW-1:0]    LAST    = SW'(NUM_STEPS - 1);
    localparam logic [WW-1:0]    WLIM    = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STEP,
        S_WAIT,
        S_DECIDE,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0] cnt_q [NUM_OUTPUTS];
    logic [CNT_W-1:0] cnt_d [NUM_OUTPUTS];
    logic [SW-1:0]    step_q, step_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic [AW-1:0]    act_q, act_d;
    logic             err_q, err_d;
    logic             clr_q, clr_d;
    logic             en_q, en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [CNT_W-1:0] best_v;
    logic [AW-1:0]    best_i;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; a completed step beats a timeout in the same cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start) state_d = S_CLEAR;
            S_CLEAR:  state_d = S_STEP;
            S_STEP:   state_d = S_WAIT;
            S_WAIT: begin
                if (step_done)
                    state_d = (step_q == LAST) ? S_DECIDE : S_STEP;
                else if (wait_q == WLIM)
                    state_d = S_DONE;
            end
            S_DECIDE: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Argmax over counters; strict compare keeps the lowest index on ties
    always_comb begin
        best_v = cnt_q[0];
        best_i = '0;
        for (int i = 1; i < NUM_OUTPUTS; i++) begin
            if (cnt_q[i] > best_v) begin
                best_v = cnt_q[i];
                best_i = AW'(i);
            end
        end
    end

    // Outputs and datapath; pulses are decoded from next state then registered
    always_comb begin
        cnt_d  = cnt_q;
        step_d = step_q;
        wait_d = wait_q;
        act_d  = act_q;
        err_d  = err_q;
        clr_d  = (state_d == S_CLEAR);
        en_d   = (state_d == S_STEP);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        if (state_d == S_CLEAR) begin
            for (int i = 0; i < NUM_OUTPUTS; i++) cnt_d[i] = '0;
            step_d = '0;
            err_d  = 1'b0;
        end
        unique case (state_q)
            S_STEP: wait_d = '0;
            S_WAIT: begin
                if (step_done) begin
                    for (int i = 0; i < NUM_OUTPUTS; i++) begin
                        if (out_spikes[i] && cnt_q[i] != CNT_MAX)
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                    if (step_q != LAST) step_d = step_q + SW'(1);
                end else begin
                    wait_d = wait_q + WW'(1);
                    if (wait_q == WLIM) err_d = 1'b1;
                end
            end
            S_DECIDE: act_d = best_i;
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '{default: '0};
            step_q <= '0;
            wait_q <= '0;
            act_q  <= '0;
            err_q  <= 1'b0;
            clr_q  <= 1'b0;
            en_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            step_q <= step_d;
            wait_q <= wait_d;
            act_q  <= act_d;
            err_q  <= err_d;
            clr_q  <= clr_d;
            en_q   <= en_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_pack
        assign spike_counts[g*CNT_W +: CNT_W] = cnt_q[g];
    end

    assign neuron_clear = clr_q;
    assign step_enable  = en_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = err_q;
    assign step_index   = step_q;
    assign action       = act_q;

endmodule

// File: tb/tb_snn_step_sequencer.sv
// Scoreboard bench for snn_step_sequencer.
// Directed runs on a 4-step and a 10-step instance.
module tb_snn_step_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n = 1'b0;
    logic       start_a = 1'b0, sd_a = 1'b0;
    logic [1:0] os_a = 2'b00;
    logic       start_b = 1'b0, sd_b = 1'b0;
    logic [1:0] os_b = 2'b00;

    logic       clr_a, en_a, busy_a, done_a, err_a, act_a;
    logic [2:0] idx_a;
    logic [5:0] cnt_a;
    logic       clr_b, en_b, busy_b, done_b, err_b, act_b;
    logic [3:0] idx_b;
    logic [5:0] cnt_b;

    snn_step_sequencer #(
        .NUM_STEPS(4), .NUM_OUTPUTS(2), .CNT_W(3), .TIMEOUT(5)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a),
        .step_done(sd_a), .out_spikes(os_a),
        .neuron_clear(clr_a), .step_enable(en_a), .busy(busy_a),
        .done(done_a), .error(err_a), .step_index(idx_a),
        .spike_counts(cnt_a), .action(act_a)
    );

    snn_step_sequencer #(
        .NUM_STEPS(10), .NUM_OUTPUTS(2), .CNT_W(3), .TIMEOUT(5)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b),
        .step_done(sd_b), .out_spikes(os_b),
        .neuron_clear(clr_b), .step_enable(en_b), .busy(busy_b),
        .done(done_b), .error(err_b), .step_index(idx_b),
        .spike_counts(cnt_b), .action(act_b)
    );

    typedef struct {
        logic [5:0] cnt;
        logic       act;
        logic       err;
    } exp_t;

    exp_t exp_a[$];
    exp_t exp_b[$];

    int total = 0, bad = 0;
    int cyc = 0;
    int t0 = 0;
    int clr_n = 0, en_n = 0, done_n = 0, done_bn = 0;
    int clr_cyc = 0, done_cyc = 0;
    int en_cyc[$];
    logic       err_at_clr;
    logic [5:0] cnt_at_clr;

    int         lat_a = 1;
    logic       lat_rnd = 1'b0;
    int         hold_step = -1;
    logic [1:0] pat_a [4];
    int         k_a = 0;
    int         r_lat;
    int         inj_n = 0, inj_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Event logger for DUT A
    initial forever begin
        @(negedge clk);
        if (clr_a) begin
            clr_n++;
            clr_cyc    = cyc - t0;
            err_at_clr = err_a;
            cnt_at_clr = cnt_a;
        end
        if (en_a) begin
            en_n++;
            en_cyc.push_back(cyc - t0);
            chk("clr_en_excl", 32'(clr_a), 32'd0);
        end
        if (done_a) begin
            done_n++;
            done_cyc = cyc - t0;
        end
        if (done_b) done_bn++;
    end

    // Scoreboard monitor
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (done_a) begin
            if (exp_a.size() == 0) begin
                total++; bad++;
                $display("FAIL sb_a: unexpected done");
            end else begin
                e = exp_a.pop_front();
                chk("sb_a_counts", 32'(cnt_a), 32'(e.cnt));
                chk("sb_a_action", 32'(act_a), 32'(e.act));
                chk("sb_a_error", 32'(err_a), 32'(e.err));
                chk("sb_a_busy", 32'(busy_a), 32'd1);
            end
        end
        if (done_b) begin
            if (exp_b.size() == 0) begin
                total++; bad++;
                $display("FAIL sb_b: unexpected done");
            end else begin
                e = exp_b.pop_front();
                chk("sb_b_counts", 32'(cnt_b), 32'(e.cnt));
                chk("sb_b_action", 32'(act_b), 32'(e.act));
                chk("sb_b_error", 32'(err_b), 32'(e.err));
            end
        end
    end

    // Layer-pipeline responder for DUT A
    initial forever begin
        @(negedge clk);
        if (inj_n != inj_seen) begin
            inj_seen = inj_n;
            #1 sd_a = 1'b1; os_a = 2'b11;
            repeat (2) @(posedge clk);
            #1 sd_a = 1'b0; os_a = 2'b00;
        end else begin
            if (clr_a) k_a = 0;
            if (en_a) begin
                chk("step_index_a", 32'(idx_a), 32'(k_a));
                r_lat = lat_rnd ? $urandom_range(1, 4) : lat_a;
                if (k_a != hold_step && k_a < 4) begin
                    repeat (r_lat) @(posedge clk);
                    #1 sd_a = 1'b1; os_a = pat_a[k_a];
                    @(posedge clk);
                    #1 sd_a = 1'b0; os_a = 2'b00;
                end
                k_a++;
            end
        end
    end

    // Layer-pipeline responder for DUT B: only output 1 fires
    initial forever begin
        @(negedge clk);
        if (en_b) begin
            @(posedge clk);
            #1 sd_b = 1'b1; os_b = 2'b10;
            @(posedge clk);
            #1 sd_b = 1'b0; os_b = 2'b00;
        end
    end

    task automatic kick_a(input logic [1:0] p0, input logic [1:0] p1,
                          input logic [1:0] p2, input logic [1:0] p3,
                          input int hold);
        pat_a[0] = p0; pat_a[1] = p1; pat_a[2] = p2; pat_a[3] = p3;
        hold_step = hold;
        tick();
        en_cyc.delete();
        t0 = cyc;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic expect_a(input logic [5:0] c, input logic a,
                            input logic e);
        exp_t x;
        x.cnt = c; x.act = a; x.err = e;
        exp_a.push_back(x);
    endtask

    task automatic finish_a(input int d0);
        int n = 0;
        while (done_n == d0 && n < 100) begin
            tick();
            n++;
        end
        if (done_n == d0) begin
            total++; bad++;
            $display("FAIL wait_done_a: no done within 100 cycles");
        end
        tick();
    endtask

    initial begin
        int d0, c0, e0, n;
        exp_t xb;

        repeat (3) tick();
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_counts", 32'(cnt_a), 32'd0);
        chk("rst_action", 32'(act_a), 32'd0);
        chk("rst_error", 32'(err_a), 32'd0);
        reset_n = 1'b1;
        repeat (2) tick();

        // Nominal run with cycle timing
        expect_a(6'h13, 1'b0, 1'b0);
        d0 = done_n;
        kick_a(2'b01, 2'b01, 2'b11, 2'b10, -1);
        finish_a(d0);
        chk("t1_clear_cyc", 32'(clr_cyc), 32'd1);
        chk("t1_en_count", 32'(en_cyc.size()), 32'd4);
        if (en_cyc.size() == 4) begin
            chk("t1_en0", 32'(en_cyc[0]), 32'd2);
            chk("t1_en1", 32'(en_cyc[1]), 32'd4);
            chk("t1_en2", 32'(en_cyc[2]), 32'd6);
            chk("t1_en3", 32'(en_cyc[3]), 32'd8);
        end
        chk("t1_done_cyc", 32'(done_cyc), 32'd11);
        chk("t1_busy_after", 32'(busy_a), 32'd0);

        // Tie resolves to output 0
        expect_a(6'h24, 1'b0, 1'b0);
        d0 = done_n;
        kick_a(2'b11, 2'b11, 2'b11, 2'b11, -1);
        finish_a(d0);

        // Saturation on the 10-step instance
        xb.cnt = 6'h38; xb.act = 1'b1; xb.err = 1'b0;
        exp_b.push_back(xb);
        d0 = done_bn;
        tick();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n = 0;
        while (done_bn == d0 && n < 200) begin
            tick();
            n++;
        end
        if (done_bn == d0) begin
            total++; bad++;
            $display("FAIL wait_done_b: no done within 200 cycles");
        end
        tick();

        // Run ending in action 1 ahead of the timeout
        expect_a(6'h18, 1'b1, 1'b0);
        d0 = done_n;
        kick_a(2'b10, 2'b10, 2'b10, 2'b00, -1);
        finish_a(d0);

        // Timeout at step 2: partial counts, action held
        expect_a(6'h12, 1'b1, 1'b1);
        d0 = done_n;
        kick_a(2'b11, 2'b11, 2'b11, 2'b11, 2);
        finish_a(d0);
        chk("t4_en_count", 32'(en_cyc.size()), 32'd3);
        if (en_cyc.size() == 3)
            chk("t4_done_rel", 32'(done_cyc - en_cyc[2]), 32'd6);
        chk("t4_done_cyc", 32'(done_cyc), 32'd12);
        chk("t4_err_held", 32'(err_a), 32'd1);
        hold_step = -1;

        // Start during WAIT is ignored; error cleared in CLEAR
        lat_a = 3;
        expect_a(6'h04, 1'b0, 1'b0);
        d0 = done_n;
        c0 = clr_n;
        kick_a(2'b01, 2'b01, 2'b01, 2'b01, -1);
        tick();
        tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        finish_a(d0);
        repeat (6) tick();
        chk("t5a_clear_once", 32'(clr_n - c0), 32'd1);
        chk("t5a_done_once", 32'(done_n - d0), 32'd1);
        chk("t5a_err_at_clr", 32'(err_at_clr), 32'd0);
        chk("t5a_cnt_at_clr", 32'(cnt_at_clr), 32'd0);
        lat_a = 1;

        // step_done while IDLE is ignored
        d0 = done_n;
        inj_n++;
        repeat (5) tick();
        chk("t5b_counts", 32'(cnt_a), 32'h04);
        chk("t5b_busy", 32'(busy_a), 32'd0);
        chk("t5b_no_done", 32'(done_n), 32'(d0));

        // Random 1..4 cycle layer latency
        lat_rnd = 1'b1;
        expect_a(6'h0b, 1'b0, 1'b0);
        d0 = done_n;
        e0 = en_n;
        kick_a(2'b01, 2'b11, 2'b01, 2'b00, -1);
        finish_a(d0);
        chk("t5c_en_pulses", 32'(en_n - e0), 32'd4);
        lat_rnd = 1'b0;

        // Reset during step 1 WAIT
        lat_a = 3;
        d0 = done_n;
        kick_a(2'b11, 2'b11, 2'b11, 2'b11, -1);
        n = 0;
        while (en_cyc.size() < 2 && n < 50) begin
            tick();
            n++;
        end
        chk("t6_reached_step1", 32'(en_cyc.size()), 32'd2);
        tick();
        chk("t6_busy_pre", 32'(busy_a), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t6_busy", 32'(busy_a), 32'd0);
        chk("t6_counts", 32'(cnt_a), 32'd0);
        chk("t6_idx", 32'(idx_a), 32'd0);
        chk("t6_pulses", 32'({clr_a, en_a, done_a, err_a}), 32'd0);
        chk("t6_action", 32'(act_a), 32'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (6) tick();
        chk("t6_no_done", 32'(done_n), 32'(d0));
        lat_a = 1;

        expect_a(6'h13, 1'b0, 1'b0);
        kick_a(2'b01, 2'b01, 2'b11, 2'b10, -1);
        finish_a(d0);
        chk("t6_rerun_done_cyc", 32'(done_cyc), 32'd11);

        repeat (4) tick();
        chk("sb_a_drained", 32'(exp_a.size()), 32'd0);
        chk("sb_b_drained", 32'(exp_b.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/snn_step_sequencer.md
# snn_step_sequencer

Timestep sequencer for the CartPole spiking network. For each inference it clears all LIF membranes, then issues one `enable` pulse per simulation timestep to the neuron layers. It waits for the layer pipeline to report completion, accumulates output-layer spikes per output neuron, and selects the action by spike-count argmax. It sits between the observation/encoder front end and the `lif` neuron array, driving the neurons' `reset` and `enable` inputs.

## Interface
- `NUM_STEPS`, 30: timesteps per inference (≥1).
- `NUM_OUTPUTS`, 2: output neurons / actions (≥2).
- `CNT_W`, 8: per-output spike counter width.
- `TIMEOUT`, 255: max WAIT cycles per step before the error abort (≥1).
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: request inference; sampled only in IDLE.
- `step_done` in 1: layer pipeline finished current timestep; `out_spikes` valid this cycle.
- `out_spikes` in NUM_OUTPUTS: output-layer spike vector for the current step.
- `neuron_clear` out 1: one-cycle pulse clearing LIF membranes/spikes (drives neuron `reset`).
- `step_enable` out 1: one-cycle pulse advancing all neurons one timestep (drives neuron `enable`).
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `error` out 1: last inference aborted by timeout; held until next start.
- `step_index` out $clog2(NUM_STEPS+1): current timestep number.
- `spike_counts` out NUM_OUTPUTS*CNT_W: packed counters, output 0 in LSBs.
- `action` out max(1,$clog2(NUM_OUTPUTS)): selected action.

## Operation
- FSM states: IDLE, CLEAR, STEP, WAIT, DECIDE, DONE.
- IDLE: `start`=1 → CLEAR. Otherwise stay.
- CLEAR: `neuron_clear`=1. Zero `spike_counts`, `step_index`, and `error`. → STEP.
- STEP: `step_enable`=1. Zero the wait counter. → WAIT.
- WAIT, on `step_done`=1:
  - Each counter i adds `out_spikes[i]`, saturating at 2^CNT_W−1 (no wrap).
  - If `step_index`==NUM_STEPS−1 → DECIDE.
  - Else increment `step_index` → STEP.
- WAIT, without `step_done`: increment the wait counter. When it reaches TIMEOUT, set `error`=1 and go → DONE, skipping DECIDE. `action` keeps its previous value and counts hold partial values.
- DECIDE: `action` ← index of the largest count. Ties resolve to the lowest index. → DONE.
- DONE: `done`=1 → IDLE.
- `start` outside IDLE is ignored; it is not queued.
- `step_done` outside WAIT is ignored, and its spikes are not counted.
- `neuron_clear` and `step_enable` are never high in the same cycle. Both are registered (glitch-free).

## Timing
- Reset values: state IDLE, all outputs 0, `spike_counts` 0, `action` 0, `error` 0.
- `reset_n` low mid-inference returns to IDLE immediately (asynchronous). No `done` is issued.
- Cycle numbering, with `start` sampled high in IDLE at cycle 0:
  - CLEAR at cycle 1.
  - Step i: STEP at cycle 2+2i, first WAIT cycle at 3+2i.
- `step_done` may arrive no earlier than the cycle after `step_enable`, i.e. the minimum layer latency is 1.
- With `step_done` in the first WAIT cycle of every step, `done` is high at cycle 2·NUM_STEPS+3 and `busy` is high for cycles 1 through 2·NUM_STEPS+3.
- `action` and final `spike_counts` are valid in the `done` cycle. They hold until the next CLEAR.
- `step_index` equals the step being executed during STEP and WAIT.
- Timeout: for a step entered at cycle s, `done` and `error` go high at cycle s+TIMEOUT+1 if `step_done` never arrives.
- Back-to-back runs: `start` held high through DONE is sampled in the following IDLE cycle, giving one idle cycle between runs.

## Test plan
Use NUM_STEPS=4, NUM_OUTPUTS=2, CNT_W=3, TIMEOUT=5, with a 1-cycle `step_done` responder.

1. Nominal run. Pulse `start`; `out_spikes` = 01, 01, 11, 10 over steps 0–3. Required:
   - `neuron_clear` at cycle 1.
   - `step_enable` at cycles 2, 4, 6, 8.
   - `done` at cycle 11.
   - Counts {out1=2, out0=3}, `action`=0.
2. Tie. `out_spikes` = 11 ×4. Required: counts {4,4}, `action`=0 (lowest index wins).
3. Saturation. Rerun with NUM_STEPS=10, `out_spikes`=10 on every step. Required: count1=7 (saturated, not wrapped), count0=0, `action`=1.
4. Timeout. Withhold `step_done` at step 2. Required:
   - `done` and `error`=1 at 6 cycles after that step's `step_enable`.
   - `action` unchanged from the previous run.
   - The next `start` clears `error` in CLEAR.
5. Protocol robustness:
   - Assert `start` during WAIT → ignored: no second CLEAR, `done` count unchanged.
   - Inject `step_done` during IDLE → counts unchanged.
   - Random multi-cycle `step_done` latencies (1–4 cycles) → correct counts and exactly 4 `step_enable` pulses.
6. Reset mid-run. Drive `reset_n` low during step 1 WAIT. Required:
   - All outputs go to 0 asynchronously, with no `done`.
   - After release, a fresh `start` completes a normal run.
